// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multi-cycle sequencer and the RV64 subset datapath.
// The sequencer drives the control strobes; the datapath drives opcode, zero and memoryReady.
interface multicycle_controller_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic [6:0]       opcode;
  logic             zero;
  logic             memoryReady;
  logic             PCWrite;
  logic             pcSrc;
  logic             IRWrite;
  logic             ALUSrc;
  logic [1:0]       ALUOp;
  logic             memoryRead;
  logic             memoryWrite;
  logic             memoryToRegister;
  logic             rWrite;
  logic             instrDone;
  logic [CNT_W-1:0] retired;
  logic             error;
  logic [3:0]       state;

  modport master (
    input  opcode, zero, memoryReady,
    output PCWrite, pcSrc, IRWrite, ALUSrc, ALUOp, memoryRead, memoryWrite,
           memoryToRegister, rWrite, instrDone, retired, error, state
  );

  modport slave (
    output opcode, zero, memoryReady,
    input  PCWrite, pcSrc, IRWrite, ALUSrc, ALUOp, memoryRead, memoryWrite,
           memoryToRegister, rWrite, instrDone, retired, error, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RV64 R/LD/SD/BEQ subset: sequences fetch, decode,
// execute, memory and writeback, with a bounded memory handshake and a retire counter.
module multicycle_controller #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  multicycle_controller_if.master  bus
);

  localparam int unsigned WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    START     = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    EXEC_R    = 4'd3,
    EXEC_ADDR = 4'd4,
    EXEC_BEQ  = 4'd5,
    MEM_RD    = 4'd6,
    MEM_WR    = 4'd7,
    WB_R      = 4'd8,
    WB_MEM    = 4'd9,
    TRAP      = 4'd10
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       r_write;
    logic       instr_done;
    logic       error;
  } ctrl_t;

  state_t              state_q;
  state_t              state_d;
  ctrl_t               ctrl_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [WAIT_W-1:0]   wait_d;
  logic [CNT_W-1:0]    retired_q;
  logic                wr_done_c;
  logic                instr_done_c;

  // Moore output decode; pc_write in EXEC_BEQ is completed by zero at the port
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:     begin c.ir_write = 1'b1; c.pc_write = 1'b1; end
      EXEC_R:    c.alu_op = 2'b10;
      EXEC_ADDR: c.alu_src = 1'b1;
      EXEC_BEQ:  begin c.alu_op = 2'b01; c.pc_src = 1'b1; c.instr_done = 1'b1; end
      MEM_RD:    begin c.alu_src = 1'b1; c.mem_read = 1'b1; end
      MEM_WR:    begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
      WB_R:      begin c.r_write = 1'b1; c.instr_done = 1'b1; end
      WB_MEM:    begin c.r_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1; end
      TRAP:      c.error = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  // Next-state and memory wait counter
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      START:  state_d = FETCH;
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_R:         state_d = EXEC_R;
          OP_LD, OP_SD: state_d = EXEC_ADDR;
          OP_BEQ:       state_d = EXEC_BEQ;
          default:      state_d = TRAP;
        endcase
      end
      EXEC_R:    state_d = WB_R;
      EXEC_ADDR: begin
        state_d = (bus.opcode == OP_SD) ? MEM_WR : MEM_RD;
        wait_d  = '0;
      end
      EXEC_BEQ:  state_d = FETCH;
      MEM_RD, MEM_WR: begin
        if (bus.memoryReady) begin
          state_d = (state_q == MEM_RD) ? WB_MEM : FETCH;
        end else if (wait_q == WAIT_W'(MEM_WAIT_MAX)) begin
          state_d = TRAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      WB_R, WB_MEM: state_d = FETCH;
      TRAP:         state_d = TRAP;
      default:      state_d = TRAP;
    endcase
  end

  // A store retires in the same cycle its handshake completes
  assign wr_done_c    = (state_q == MEM_WR) && bus.memoryReady;
  assign instr_done_c = ctrl_q.instr_done || wr_done_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= START;
      ctrl_q    <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d);
      wait_q  <= wait_d;
      if (instr_done_c) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign bus.PCWrite          = ctrl_q.pc_write || ((state_q == EXEC_BEQ) && bus.zero);
  assign bus.pcSrc            = ctrl_q.pc_src;
  assign bus.IRWrite          = ctrl_q.ir_write;
  assign bus.ALUSrc           = ctrl_q.alu_src;
  assign bus.ALUOp            = ctrl_q.alu_op;
  assign bus.memoryRead       = ctrl_q.mem_read;
  assign bus.memoryWrite      = ctrl_q.mem_write;
  assign bus.memoryToRegister = ctrl_q.mem_to_reg;
  assign bus.rWrite           = ctrl_q.r_write;
  assign bus.instrDone        = instr_done_c;
  assign bus.retired          = retired_q;
  assign bus.error            = ctrl_q.error;
  assign bus.state            = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-instruction expectations from a
// latency/strobe model are queued at issue and checked by an independent monitor.
module tb_multicycle_controller;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned MAX   = 15;

  localparam int K_R = 0, K_LD = 1, K_SD = 2, K_BEQ = 3, K_ILL = 4;

  typedef struct {
    int lat; int rd; int wr; int rw; int m2r; int taken; int is_beq;
    int trap; int aluop; int alusrc; int ret;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  multicycle_controller_if #(.CNT_W(CNT_W)) bus ();
  multicycle_controller #(.MEM_WAIT_MAX(MAX), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  int   ret_model = 0;
  int   cur_delay = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int strobes();
    return int'({bus.PCWrite, bus.IRWrite, bus.memoryRead, bus.memoryWrite,
                 bus.rWrite, bus.instrDone});
  endfunction

  // Reference: latency and strobe counts derived from the instruction class and ready delay
  function automatic exp_t model(input int kind, input int z, input int d);
    exp_t e;
    e = '{default: 0};
    e.ret = ret_model % (1 << CNT_W);
    case (kind)
      K_R:   begin e.lat = 4; e.rw = 1; e.aluop = 2; end
      K_BEQ: begin e.lat = 3; e.taken = z; e.is_beq = 1; e.aluop = 1; end
      K_LD, K_SD: begin
        e.alusrc = 1;
        if (d <= int'(MAX)) begin
          e.lat = (kind == K_LD) ? 5 + d : 4 + d;
          if (kind == K_LD) begin e.rd = d + 1; e.rw = 1; e.m2r = 1; end
          else e.wr = d + 1;
        end else begin
          e.trap = 1;
          e.lat  = int'(MAX) + 5;
          if (kind == K_LD) e.rd = int'(MAX) + 1; else e.wr = int'(MAX) + 1;
        end
      end
      default: begin e.lat = 3; e.trap = 1; end
    endcase
    return e;
  endfunction

  function automatic logic [6:0] opc(input int kind, input logic [6:0] ill);
    case (kind)
      K_R:     return 7'b0110011;
      K_LD:    return 7'b0000011;
      K_SD:    return 7'b0100011;
      K_BEQ:   return 7'b1100011;
      default: return ill;
    endcase
  endfunction

  // Data memory responder: ready after cur_delay wait cycles, noise outside memory states
  int mcnt = 0;
  always begin
    @(posedge clock);
    #1;
    if (reset) begin
      mcnt = 0;
      bus.memoryReady = 1'b0;
    end else if (bus.memoryRead || bus.memoryWrite) begin
      bus.memoryReady = (mcnt == cur_delay);
      mcnt++;
    end else begin
      mcnt = 0;
      bus.memoryReady = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: accumulate per-instruction observations, compare on retire or trap
  int   lat, rd, wr, rw, m2r, aluop, alusrc;
  bit   active = 0, err_seen = 0;
  exp_t e;
  always @(negedge clock) begin
    if (reset) begin
      active   = 0;
      err_seen = 0;
    end else begin
      if (bus.IRWrite) begin
        active = 1; lat = 1; rd = 0; wr = 0; rw = 0; m2r = 0; aluop = 0; alusrc = 0;
        check("fetch_pc", int'({bus.PCWrite, bus.pcSrc}), 2);
      end else if (active) begin
        lat++;
      end
      if (active) begin
        rd += int'(bus.memoryRead);
        wr += int'(bus.memoryWrite);
        if (bus.rWrite) begin rw++; m2r = int'(bus.memoryToRegister); end
        if (lat == 3) begin aluop = int'(bus.ALUOp); alusrc = int'(bus.ALUSrc); end
      end
      if (bus.instrDone || (bus.error && !err_seen)) begin
        if (bus.error) err_seen = 1;
        if (q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          e = q.pop_front();
          check("trap",    int'(bus.error), e.trap);
          check("latency", lat, e.lat);
          check("rd_cyc",  rd, e.rd);
          check("wr_cyc",  wr, e.wr);
          check("rwrite",  rw, e.rw);
          check("mem2reg", m2r, e.m2r);
          check("aluop",   aluop, e.aluop);
          check("alusrc",  alusrc, e.alusrc);
          check("pc_done", int'({bus.PCWrite, bus.pcSrc}), e.taken * 2 + e.is_beq);
          check("retired", int'(bus.retired), e.ret);
        end
        active = 0;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    q.delete();
    ret_model = 0;
    #1;
    check("rst_state",   int'(bus.state), 0);
    check("rst_retired", int'(bus.retired), 0);
    check("rst_error",   int'(bus.error), 0);
    check("rst_strobes", strobes(), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic issue(input int kind, input int z, input int d, input logic [6:0] ill);
    bit got;
    exp_t x;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.IRWrite) begin got = 1; break; end
    end
    if (!got) begin
      check("fetch_timeout", 0, 1);
      return;
    end
    bus.opcode = opc(kind, ill);
    bus.zero   = 1'(z);
    cur_delay  = d;
    x = model(kind, z, d);
    q.push_back(x);
    if (x.trap == 0) ret_model++;
  endtask

  task automatic end_phase();
    bit done;
    done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      #1;
      if (q.size() == 0) begin done = 1; break; end
    end
    if (!done) check("drain_timeout", 0, 1);
    @(negedge clock);
    check("phase_retired", int'(bus.retired), ret_model % (1 << CNT_W));
    do_reset();
  endtask

  task automatic trap_phase(input int kind, input int d, input logic [6:0] ill);
    bit got;
    got = 0;
    issue(kind, 0, d, ill);
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (bus.error) begin got = 1; break; end
    end
    if (!got) check("trap_timeout", 0, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("trap_hold_err",   int'(bus.error), 1);
      check("trap_hold_strb",  strobes(), 0);
      check("trap_hold_state", int'(bus.state), 10);
    end
    check("trap_q_empty", q.size(), 0);
    do_reset();
  endtask

  task automatic random_run(input int n);
    int k, z, d;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 3);
      z = $urandom_range(0, 1);
      d = ($urandom_range(0, 7) == 0) ? int'(MAX) : $urandom_range(0, 4);
      issue(k, z, d, 7'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [6:0] ill;
    bit got;
    bus.opcode = 7'd0;
    bus.zero   = 1'b0;
    @(negedge clock);
    do_reset();

    // Directed classes, ready-wait boundaries, then random mix
    issue(K_R, 0, 0, 7'd0);
    issue(K_LD, 0, 2, 7'd0);
    issue(K_SD, 0, 0, 7'd0);
    issue(K_BEQ, 1, 0, 7'd0);
    issue(K_BEQ, 0, 0, 7'd0);
    issue(K_LD, 0, int'(MAX), 7'd0);
    issue(K_SD, 0, int'(MAX), 7'd0);
    random_run(40);
    end_phase();

    // Sixteen branches wrap the 4-bit counter back to zero
    for (int i = 0; i < 16; i++) issue(K_BEQ, $urandom_range(0, 1), 0, 7'd0);
    end_phase();

    trap_phase(K_ILL, 0, 7'b0010011);
    trap_phase(K_LD, 1000, 7'd0);
    trap_phase(K_SD, 1000, 7'd0);

    // Reset while a store is waiting for memory
    issue(K_R, 0, 0, 7'd0);
    issue(K_BEQ, 1, 0, 7'd0);
    issue(K_SD, 0, 10, 7'd0);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.memoryWrite) begin got = 1; break; end
    end
    if (!got) check("memwr_timeout", 0, 1);
    repeat (2) @(negedge clock);
    check("pre_rst_retired", int'(bus.retired), 2);
    do_reset();

    random_run(30);
    end_phase();

    do begin
      ill = 7'($urandom_range(0, 127));
    end while (ill == 7'b0110011 || ill == 7'b0000011 || ill == 7'b0100011 || ill == 7'b1100011);
    trap_phase(K_ILL, 0, ill);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
